stack_ptr_unit: RTL and testbench
=================================

Name: stack_ptr_unit

Overview:
- Parametrised, clocked stack-pointer unit for the CPU datapath; successor to the single-register push/pop stack pointer.
- Owns the SP register and an occupancy counter.
- Generates data-memory addresses for push (write) and pop/top (read).
- Flags full/empty, latches sticky overflow/underflow/load errors, and supports an explicit SP load for context switch.
- Sits between the control unit (push/pop strobes) and the data-memory address mux.

Parameters:
- AW, 32, address/SP width in bits.
- BASE, 512, SP value of an empty stack (byte address).
- DEPTH, 64, maximum number of stacked words (≥2).
- WB, 4, bytes per stack word (power of two).
- GROW_DOWN, 0, 0 = push increments SP; 1 = push decrements SP.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- push  in  1  push request, one word per cycle.
- pop  in  1  pop request, one word per cycle.
- sp_ld  in  1  load SP from sp_ld_val.
- sp_ld_val  in  AW  new SP value.
- err_clr  in  1  clear all sticky error flags.
- sp_out  out  AW  current SP (next free slot), registered.
- wr_addr  out  AW  address for push write data, combinational from registers.
- rd_addr  out  AW  address of current top of stack, combinational from registers.
- mem_we  out  1  push accepted this cycle (write strobe to data memory).
- count  out  $clog2(DEPTH+1)  words currently stacked, registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf_err  out  1  sticky: push refused or wrapped at full.
- udf_err  out  1  sticky: pop at empty.
- ld_err  out  1  sticky: illegal sp_ld value.

Behaviour:
- Reset: sp_out=BASE, count=0, empty=1, full=0, all error flags 0, mem_we=0. rst has priority over every other input, including mid-burst.
- Priority below reset: sp_ld > push/pop. err_clr acts in parallel; a new error in the same cycle wins over clear.
- Invariant: sp_out = BASE + count·WB (up) or BASE − count·WB (down). Both registers update together.
- Address generation:
  - Grow-up: wr_addr=sp_out, rd_addr=sp_out−WB.
  - Grow-down: wr_addr=sp_out−WB, rd_addr=sp_out.
  - All arithmetic is modulo 2^AW. rd_addr is don't-care when empty.
- Push only, not full: mem_we=1 in the same cycle; next cycle count+1, SP moves by WB.
- Pop only, not empty: rd_addr is valid in the request cycle (memory reads combinationally or registers it); next cycle count−1, SP moves back by WB.
- Push and pop together, count>0: replace-top. mem_we=1 with wr_addr forced to the top address (rd_addr); SP and count unchanged.
- Push and pop together, empty: no-op, no error, mem_we=0.
- Push at full: mem_we=0, ovf_err←1. SP/count behaviour depends on STACK_WRAP_EN (see Optional Feature).
- Pop at empty: SP and count hold, udf_err←1.
- sp_ld: accepted only if the value is WB-aligned and within [BASE, BASE+DEPTH·WB] (up) or [BASE−DEPTH·WB, BASE] (down). Then sp_out←sp_ld_val and count←|sp_ld_val−BASE|/WB. Otherwise no change and ld_err←1. push/pop in the same cycle are ignored.
- Latency: every state change is visible on outputs one clock after the request. wr_addr/rd_addr/mem_we reflect the current registers and request with zero latency.

Optional Feature:
- Macro: STACK_WRAP_EN.
- Defined (legacy-compatible): push at full sets ovf_err, suppresses the write, and wraps the stack — sp_out←BASE, count←0.
- Undefined (default): push at full saturates — SP and count hold, ovf_err set.
- Pop at empty behaves identically in both builds.

Decomposition:
- Shared package stack_pkg holds:
  - Request encoding constants: STK_NOP, STK_PUSH, STK_POP, STK_REPL.
  - Error-bit index constants for a future status CSR.
  - Default BASE/DEPTH/WB constants reused by the memory map.
- One natural sub-module: stack_ld_check (combinational alignment/range checker for sp_ld_val, returns the legal flag and the derived count). The rest stays flat.

Test Plan:
- Reset then 3 pushes (defaults) → sp_out 512→516→520→524, wr_addr 512/516/520, count=3, mem_we high on each push cycle.
- From count=3, push+pop together → mem_we=1, wr_addr=520, sp_out stays 524; then pop 3 times → sp_out=512, empty=1; 4th pop → udf_err=1, sp_out=512.
- 64 pushes → full=1, sp_out=768; 65th push → ovf_err=1, mem_we=0; sp_out=768 without STACK_WRAP_EN, 512 with count=0 when STACK_WRAP_EN is defined.
- sp_ld 600 → sp_out=600, count=22; sp_ld 602 (misaligned) and sp_ld 772 (out of range) → ld_err=1, sp_out stays 600; err_clr → all flags 0.
- GROW_DOWN=1, BASE=1024: 2 pushes → wr_addr 1020 then 1016, sp_out=1016, rd_addr=1016.
- rst asserted during a push burst at count=10 → next cycle sp_out=512, count=0, all errors 0, mem_we=0 while rst is high.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared stack constants: request encoding, sticky error bit positions, default memory-map geometry.
package stack_pkg;

    localparam logic [1:0] STK_NOP  = 2'b00;
    localparam logic [1:0] STK_POP  = 2'b01;
    localparam logic [1:0] STK_PUSH = 2'b10;
    localparam logic [1:0] STK_REPL = 2'b11;

    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;
    localparam int ERR_LD_BIT  = 2;
    localparam int ERR_W       = 3;

    localparam int unsigned STK_BASE  = 512;
    localparam int unsigned STK_DEPTH = 64;
    localparam int unsigned STK_WB    = 4;

endpackage

// File: rtl/stack_ptr_unit_if.sv
// Control-unit <-> stack pointer unit bus; master drives requests, slave returns SP, addresses and flags.
interface stack_ptr_unit_if #(
    parameter int AW = 32,
    parameter int CW = 7
);
    logic          push;
    logic          pop;
    logic          sp_ld;
    logic [AW-1:0] sp_ld_val;
    logic          err_clr;
    logic [AW-1:0] sp_out;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          mem_we;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          udf_err;
    logic          ld_err;

    modport master (
        output push, pop, sp_ld, sp_ld_val, err_clr,
        input  sp_out, wr_addr, rd_addr, mem_we, count, full, empty, ovf_err, udf_err, ld_err
    );

    modport slave (
        input  push, pop, sp_ld, sp_ld_val, err_clr,
        output sp_out, wr_addr, rd_addr, mem_we, count, full, empty, ovf_err, udf_err, ld_err
    );
endinterface

// File: rtl/stack_ld_check.sv
// Combinational legality check for an SP load: WB alignment and range on the growth side of BASE.
// Also derives the occupancy implied by the loaded value.
module stack_ld_check
    import stack_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int unsigned BASE      = STK_BASE,
    parameter int unsigned DEPTH     = STK_DEPTH,
    parameter int unsigned WB        = STK_WB,
    parameter bit          GROW_DOWN = 1'b0,
    parameter int          CW        = $clog2(DEPTH + 1)
) (
    input  logic [AW-1:0] val,
    output logic          legal,
    output logic [CW-1:0] cnt
);
    localparam logic [AW-1:0] BASE_V = AW'(BASE);
    localparam logic [AW-1:0] MASK_V = AW'(WB - 1);
    localparam logic [AW:0]   SPAN_V = (AW + 1)'(DEPTH * WB);
    localparam int            SH     = $clog2(WB);

    logic [AW-1:0] diff;
    logic          in_dir;
    logic          aligned;

    always_comb begin
        diff    = GROW_DOWN ? (BASE_V - val) : (val - BASE_V);
        in_dir  = GROW_DOWN ? (val <= BASE_V) : (val >= BASE_V);
        aligned = ((val & MASK_V) == '0);
        legal   = aligned && in_dir && ({1'b0, diff} <= SPAN_V);
        cnt     = CW'(diff >> SH);
    end
endmodule

// File: rtl/stack_ptr_unit.sv
// SP register + occupancy counter with push/pop/replace-top addressing; state updates one clock after request,
// addresses and mem_we are zero-latency. No backpressure: refused requests raise sticky errors. Wrap-at-full under STACK_WRAP_EN.
module stack_ptr_unit
    import stack_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int unsigned BASE      = STK_BASE,
    parameter int unsigned DEPTH     = STK_DEPTH,
    parameter int unsigned WB        = STK_WB,
    parameter bit          GROW_DOWN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    stack_ptr_unit_if.slave bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] BASE_V  = AW'(BASE);
    localparam logic [AW-1:0] STEP_V  = AW'(WB);
    localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

    logic [AW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             we;
    logic             ld_ok;
    logic [CW-1:0]    ld_cnt;
    logic             full, empty;
    logic [AW-1:0]    top_addr, push_addr, sp_fwd, sp_back;
    logic [1:0]       req;

    stack_ld_check #(
        .AW(AW), .BASE(BASE), .DEPTH(DEPTH), .WB(WB), .GROW_DOWN(GROW_DOWN), .CW(CW)
    ) u_ld_check (
        .val   (bus.sp_ld_val),
        .legal (ld_ok),
        .cnt   (ld_cnt)
    );

    assign req       = {bus.push, bus.pop};
    assign full      = (count_q == DEPTH_V);
    assign empty     = (count_q == '0);
    assign sp_fwd    = GROW_DOWN ? (sp_q - STEP_V) : (sp_q + STEP_V);
    assign sp_back   = GROW_DOWN ? (sp_q + STEP_V) : (sp_q - STEP_V);
    assign top_addr  = GROW_DOWN ? sp_q : (sp_q - STEP_V);
    assign push_addr = GROW_DOWN ? (sp_q - STEP_V) : sp_q;

    // A new error raised this cycle overrides err_clr because it is applied after the clear.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        err_d   = bus.err_clr ? '0 : err_q;
        we      = 1'b0;
        if (bus.sp_ld) begin
            if (ld_ok) begin
                sp_d    = bus.sp_ld_val;
                count_d = ld_cnt;
            end else begin
                err_d[ERR_LD_BIT] = 1'b1;
            end
        end else begin
            case (req)
                STK_PUSH: begin
                    if (!full) begin
                        we      = 1'b1;
                        sp_d    = sp_fwd;
                        count_d = count_q + CW'(1);
                    end else begin
                        err_d[ERR_OVF_BIT] = 1'b1;
`ifdef STACK_WRAP_EN
                        sp_d    = BASE_V;
                        count_d = '0;
`endif
                    end
                end
                STK_POP: begin
                    if (!empty) begin
                        sp_d    = sp_back;
                        count_d = count_q - CW'(1);
                    end else begin
                        err_d[ERR_UDF_BIT] = 1'b1;
                    end
                end
                STK_REPL: we = !empty;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= BASE_V;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.sp_out  = sp_q;
    assign bus.count   = count_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.rd_addr = top_addr;
    assign bus.wr_addr = (req == STK_REPL) ? top_addr : push_addr;
    assign bus.mem_we  = we & ~rst;
    assign bus.ovf_err = err_q[ERR_OVF_BIT];
    assign bus.udf_err = err_q[ERR_UDF_BIT];
    assign bus.ld_err  = err_q[ERR_LD_BIT];
endmodule

// File: tb/tb_stack_ptr_unit.sv
// Bench for stack_ptr_unit: directed scenarios plus randomized traffic against an occupancy-level model.
module tb_stack_ptr_unit;
    localparam int AW    = 32;
    localparam int BASE  = 512;
    localparam int DEPTH = 64;
    localparam int WB    = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int DBASE = 1024;
`ifdef STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_ptr_unit_if #(.AW(AW), .CW(CW)) up_if ();
    stack_ptr_unit_if #(.AW(AW), .CW(CW)) dn_if ();

    stack_ptr_unit #(.AW(AW), .BASE(BASE), .DEPTH(DEPTH), .WB(WB), .GROW_DOWN(1'b0)) u_up (
        .clk(clk), .rst(rst), .bus(up_if.slave));
    stack_ptr_unit #(.AW(AW), .BASE(DBASE), .DEPTH(DEPTH), .WB(WB), .GROW_DOWN(1'b1)) u_dn (
        .clk(clk), .rst(rst), .bus(dn_if.slave));

    int checks = 0;
    int failures = 0;

    // Reference model: the stack is just an occupancy number plus three sticky bits.
    int m_count = 0;
    bit m_ovf = 0, m_udf = 0, m_ld = 0;

    function automatic int exp_sp();
        return BASE + m_count * WB;
    endfunction

    function automatic bit exp_we();
        if (rst || up_if.sp_ld || !up_if.push) return 1'b0;
        if (up_if.pop) return m_count > 0;
        return m_count < DEPTH;
    endfunction

    function automatic int exp_wr();
        if (up_if.push && up_if.pop) return BASE + (m_count - 1) * WB;
        return BASE + m_count * WB;
    endfunction

    task automatic drive(input bit r, input bit p, input bit q, input bit ld,
                         input logic [AW-1:0] v, input bit clr);
        @(negedge clk);
        rst = r;
        up_if.push = p;
        up_if.pop = q;
        up_if.sp_ld = ld;
        up_if.sp_ld_val = v;
        up_if.err_clr = clr;
        #1;
    endtask

    task automatic tick();
        longint v;
        @(posedge clk);
        v = longint'(up_if.sp_ld_val);
        if (rst) begin
            m_count = 0; m_ovf = 0; m_udf = 0; m_ld = 0;
        end else begin
            if (up_if.err_clr) begin m_ovf = 0; m_udf = 0; m_ld = 0; end
            if (up_if.sp_ld) begin
                if ((v % WB) == 0 && v >= BASE && v <= BASE + DEPTH * WB) m_count = int'((v - BASE) / WB);
                else m_ld = 1;
            end else if (up_if.push && up_if.pop) begin
                // replace-top or empty no-op: occupancy unchanged
            end else if (up_if.push) begin
                if (m_count < DEPTH) m_count++;
                else begin m_ovf = 1; if (WRAP) m_count = 0; end
            end else if (up_if.pop) begin
                if (m_count > 0) m_count--;
                else m_udf = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, '0, 0); tick(); tick();
        drive(0, 0, 0, 0, '0, 0);
        checks++; if (up_if.sp_out !== AW'(BASE)) begin failures++; $display("FAIL reset_sp got %0d want %0d", up_if.sp_out, BASE); end
        checks++; if (up_if.count !== '0) begin failures++; $display("FAIL reset_count got %0d want 0", up_if.count); end
        checks++; if (up_if.empty !== 1'b1 || up_if.full !== 1'b0) begin failures++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", up_if.empty, up_if.full); end
        checks++; if ({up_if.ovf_err, up_if.udf_err, up_if.ld_err} !== 3'b000) begin failures++; $display("FAIL reset_err got %b want 000", {up_if.ovf_err, up_if.udf_err, up_if.ld_err}); end
        checks++; if (up_if.mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b want 0", up_if.mem_we); end
    endtask

    task automatic test_push3();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, '0, 0);
            checks++; if (up_if.mem_we !== 1'b1) begin failures++; $display("FAIL push3_we[%0d] got %b want 1", i, up_if.mem_we); end
            checks++; if (up_if.wr_addr !== AW'(BASE + 4 * i)) begin failures++; $display("FAIL push3_wr[%0d] got %0d want %0d", i, up_if.wr_addr, BASE + 4 * i); end
            tick();
            checks++; if (up_if.sp_out !== AW'(BASE + 4 * (i + 1))) begin failures++; $display("FAIL push3_sp[%0d] got %0d want %0d", i, up_if.sp_out, BASE + 4 * (i + 1)); end
        end
        checks++; if (up_if.count !== CW'(3)) begin failures++; $display("FAIL push3_count got %0d want 3", up_if.count); end
    endtask

    task automatic test_replace_and_pop();
        drive(0, 1, 1, 0, '0, 0);
        checks++; if (up_if.mem_we !== 1'b1 || up_if.wr_addr !== AW'(520)) begin failures++; $display("FAIL repl_wr got we=%b addr=%0d want we=1 addr=520", up_if.mem_we, up_if.wr_addr); end
        tick();
        checks++; if (up_if.sp_out !== AW'(524)) begin failures++; $display("FAIL repl_sp got %0d want 524", up_if.sp_out); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, '0, 0);
            checks++; if (up_if.rd_addr !== AW'(520 - 4 * i)) begin failures++; $display("FAIL pop_rd[%0d] got %0d want %0d", i, up_if.rd_addr, 520 - 4 * i); end
            tick();
        end
        checks++; if (up_if.sp_out !== AW'(512) || up_if.empty !== 1'b1) begin failures++; $display("FAIL pop_empty got sp=%0d e=%b want sp=512 e=1", up_if.sp_out, up_if.empty); end
        drive(0, 0, 1, 0, '0, 0); tick();
        checks++; if (up_if.udf_err !== 1'b1 || up_if.sp_out !== AW'(512)) begin failures++; $display("FAIL udf got err=%b sp=%0d want err=1 sp=512", up_if.udf_err, up_if.sp_out); end
        drive(0, 1, 1, 0, '0, 0);
        checks++; if (up_if.mem_we !== 1'b0) begin failures++; $display("FAIL repl_empty_we got %b want 0", up_if.mem_we); end
        tick();
    endtask

    task automatic test_full();
        drive(1, 0, 0, 0, '0, 0); tick();
        for (int i = 0; i < DEPTH; i++) begin drive(0, 1, 0, 0, '0, 0); tick(); end
        checks++; if (up_if.full !== 1'b1 || up_if.sp_out !== AW'(768)) begin failures++; $display("FAIL full got f=%b sp=%0d want f=1 sp=768", up_if.full, up_if.sp_out); end
        drive(0, 1, 0, 0, '0, 0);
        checks++; if (up_if.mem_we !== 1'b0) begin failures++; $display("FAIL ovf_we got %b want 0", up_if.mem_we); end
        tick();
        checks++; if (up_if.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_err got %b want 1", up_if.ovf_err); end
        checks++; if (up_if.sp_out !== AW'(WRAP ? 512 : 768) || up_if.count !== CW'(WRAP ? 0 : 64)) begin failures++; $display("FAIL ovf_sp got sp=%0d cnt=%0d want sp=%0d cnt=%0d", up_if.sp_out, up_if.count, WRAP ? 512 : 768, WRAP ? 0 : 64); end
    endtask

    task automatic test_sp_ld();
        drive(1, 0, 0, 0, '0, 0); tick();
        drive(0, 1, 0, 1, AW'(600), 0);
        checks++; if (up_if.mem_we !== 1'b0) begin failures++; $display("FAIL ld_we got %b want 0", up_if.mem_we); end
        tick();
        checks++; if (up_if.sp_out !== AW'(600) || up_if.count !== CW'(22)) begin failures++; $display("FAIL ld600 got sp=%0d cnt=%0d want sp=600 cnt=22", up_if.sp_out, up_if.count); end
        drive(0, 0, 0, 1, AW'(602), 0); tick();
        checks++; if (up_if.ld_err !== 1'b1 || up_if.sp_out !== AW'(600)) begin failures++; $display("FAIL ld602 got err=%b sp=%0d want err=1 sp=600", up_if.ld_err, up_if.sp_out); end
        drive(0, 0, 0, 0, '0, 1); tick();
        checks++; if (up_if.ld_err !== 1'b0) begin failures++; $display("FAIL ld_clr got %b want 0", up_if.ld_err); end
        drive(0, 0, 0, 1, AW'(772), 1); tick();
        checks++; if (up_if.ld_err !== 1'b1 || up_if.sp_out !== AW'(600)) begin failures++; $display("FAIL ld772 got err=%b sp=%0d want err=1 sp=600", up_if.ld_err, up_if.sp_out); end
        drive(0, 0, 0, 1, AW'(768), 0); tick();
        checks++; if (up_if.full !== 1'b1 || up_if.count !== CW'(64)) begin failures++; $display("FAIL ld768 got f=%b cnt=%0d want f=1 cnt=64", up_if.full, up_if.count); end
        drive(0, 0, 0, 0, '0, 1); tick();
        checks++; if ({up_if.ovf_err, up_if.udf_err, up_if.ld_err} !== 3'b000) begin failures++; $display("FAIL clr_all got %b want 000", {up_if.ovf_err, up_if.udf_err, up_if.ld_err}); end
        drive(0, 0, 0, 0, '0, 0);
    endtask

    task automatic test_grow_down();
        drive(1, 0, 0, 0, '0, 0); tick();
        drive(0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 2; i++) begin
            dn_if.push = 1'b1;
            #1;
            checks++; if (dn_if.mem_we !== 1'b1 || dn_if.wr_addr !== AW'(DBASE - 4 * (i + 1))) begin failures++; $display("FAIL dn_wr[%0d] got we=%b addr=%0d want we=1 addr=%0d", i, dn_if.mem_we, dn_if.wr_addr, DBASE - 4 * (i + 1)); end
            @(posedge clk); #1;
            dn_if.push = 1'b0;
            @(negedge clk);
        end
        #1;
        checks++; if (dn_if.sp_out !== AW'(1016) || dn_if.rd_addr !== AW'(1016)) begin failures++; $display("FAIL dn_sp got sp=%0d rd=%0d want 1016/1016", dn_if.sp_out, dn_if.rd_addr); end
    endtask

    task automatic test_reset_mid_burst();
        drive(1, 0, 0, 0, '0, 0); tick();
        for (int i = 0; i < 10; i++) begin drive(0, 1, 0, 0, '0, 0); tick(); end
        drive(0, 0, 1, 0, '0, 0); tick();
        drive(0, 0, 1, 0, '0, 0); tick();
        drive(0, 0, 0, 0, '0, 0); tick();
        for (int i = 0; i < 2; i++) begin drive(0, 1, 0, 0, '0, 0); tick(); end
        checks++; if (up_if.count !== CW'(10)) begin failures++; $display("FAIL burst_count got %0d want 10", up_if.count); end
        drive(1, 1, 0, 0, '0, 0);
        checks++; if (up_if.mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b want 0", up_if.mem_we); end
        tick();
        checks++; if (up_if.sp_out !== AW'(512) || up_if.count !== '0 || up_if.mem_we !== 1'b0) begin failures++; $display("FAIL rst_burst got sp=%0d cnt=%0d we=%b want 512/0/0", up_if.sp_out, up_if.count, up_if.mem_we); end
        drive(0, 0, 0, 0, '0, 0);
    endtask

    task automatic test_random();
        int pp, pq;
        for (int i = 0; i < 600; i++) begin
            case (i / 150)
                0: begin pp = 80; pq = 15; end
                1: begin pp = 20; pq = 70; end
                2: begin pp = 95; pq = 5; end
                default: begin pp = 50; pq = 50; end
            endcase
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq,
                  $urandom_range(0, 19) == 0,
                  AW'(BASE - 8 + $urandom_range(0, DEPTH * WB + 16)),
                  $urandom_range(0, 15) == 0);
            checks++; if (up_if.mem_we !== exp_we()) begin failures++; $display("FAIL rnd_we[%0d] got %b want %b", i, up_if.mem_we, exp_we()); end
            if (exp_we()) begin
                checks++; if (up_if.wr_addr !== AW'(exp_wr())) begin failures++; $display("FAIL rnd_wr[%0d] got %0d want %0d", i, up_if.wr_addr, exp_wr()); end
            end
            if (m_count > 0) begin
                checks++; if (up_if.rd_addr !== AW'(exp_sp() - WB)) begin failures++; $display("FAIL rnd_rd[%0d] got %0d want %0d", i, up_if.rd_addr, exp_sp() - WB); end
            end
            tick();
            checks++; if (up_if.sp_out !== AW'(exp_sp()) || up_if.count !== CW'(m_count)) begin failures++; $display("FAIL rnd_state[%0d] got sp=%0d cnt=%0d want sp=%0d cnt=%0d", i, up_if.sp_out, up_if.count, exp_sp(), m_count); end
            checks++; if (up_if.full !== (m_count == DEPTH) || up_if.empty !== (m_count == 0)) begin failures++; $display("FAIL rnd_flags[%0d] got f=%b e=%b want f=%b e=%b", i, up_if.full, up_if.empty, m_count == DEPTH, m_count == 0); end
            checks++; if ({up_if.ovf_err, up_if.udf_err, up_if.ld_err} !== {m_ovf, m_udf, m_ld}) begin failures++; $display("FAIL rnd_err[%0d] got %b want %b", i, {up_if.ovf_err, up_if.udf_err, up_if.ld_err}, {m_ovf, m_udf, m_ld}); end
        end
    endtask

    initial begin
        up_if.push = 0; up_if.pop = 0; up_if.sp_ld = 0; up_if.sp_ld_val = '0; up_if.err_clr = 0;
        dn_if.push = 0; dn_if.pop = 0; dn_if.sp_ld = 0; dn_if.sp_ld_val = '0; dn_if.err_clr = 0;
        test_reset();
        test_push3();
        test_replace_and_pop();
        test_full();
        test_sp_ld();
        test_grow_down();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
